// File: rtl/nsum_pkg.sv
// nsum_pkg: shared widths, requester state encoding and the triangular-sum reference
package nsum_pkg;
    localparam int N_W = 3;
    localparam int SUM_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} nsum_req_state_t;

    function automatic logic [SUM_W-1:0] expected_sum(input logic [N_W-1:0] n);
        logic [2*N_W-1:0] p;
        p = {{N_W{1'b0}}, n} * ({{N_W{1'b0}}, n} + (2*N_W)'(1));
        return p[SUM_W:1];
    endfunction
endpackage

// File: rtl/nsum_requester_if.sv
// nsum_requester_if: command, responder and result signals of the NSum requester
interface nsum_requester_if
    import nsum_pkg::*;
#(
    parameter int ERR_W = 8
);
    logic             cmd_valid;
    logic [N_W-1:0]   cmd_n;
    logic             cmd_ready;
    logic [N_W-1:0]   N;
    logic             N_valid;
    logic [SUM_W-1:0] sum;
    logic             sum_valid;
    logic             rsp_valid;
    logic [SUM_W-1:0] rsp_sum;
    logic             rsp_match;
    logic             rsp_timeout;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        input  cmd_valid, cmd_n, sum, sum_valid,
        output cmd_ready, N, N_valid, rsp_valid, rsp_sum, rsp_match, rsp_timeout, err_cnt
    );

    modport slave (
        output cmd_valid, cmd_n, sum, sum_valid,
        input  cmd_ready, N, N_valid, rsp_valid, rsp_sum, rsp_match, rsp_timeout, err_cnt
    );
endinterface

// File: rtl/nsum_timer.sv
// nsum_timer: clearable up-counter; hit flags the increment that reaches TIMEOUT
module nsum_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);
    logic [7:0] cnt;

    assign hit = en && (cnt == 8'(TIMEOUT - 1));

    // count WAIT cycles since the last clear
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/nsum_requester.sv
// nsum_requester: issues N to an NSum responder, times the reply and scores it
module nsum_requester
    import nsum_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ERR_W = 8
) (
    input logic clk,
    input logic reset,
    nsum_requester_if.master bus
);
    nsum_req_state_t state;
    logic hit;
    logic [1:0] inc;
    logic [ERR_W:0] err_sum;

    nsum_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .reset(reset),
        .clr(state == ISSUE),
        .en(state == WAIT),
        .hit(hit)
    );

    // a failed RESP and a stray sum_valid in the same cycle each count once
    always_comb begin
        inc = 2'(state != WAIT && bus.sum_valid) + 2'(state == RESP && !bus.rsp_match);
        err_sum = {1'b0, bus.err_cnt} + (ERR_W + 1)'(inc);
    end

    // request FSM with registered outputs and saturating error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus.cmd_ready   <= 1'b1;
            bus.N           <= '0;
            bus.N_valid     <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_sum     <= '0;
            bus.rsp_match   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.err_cnt     <= '0;
        end else begin
            bus.err_cnt <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    state         <= ISSUE;
                    bus.cmd_ready <= 1'b0;
                    bus.N         <= bus.cmd_n;
                    bus.N_valid   <= 1'b1;
                end
                ISSUE: begin
                    state       <= WAIT;
                    bus.N_valid <= 1'b0;
                end
                WAIT: if (bus.sum_valid || hit) begin
                    state           <= RESP;
                    bus.rsp_valid   <= 1'b1;
                    bus.rsp_sum     <= bus.sum_valid ? bus.sum : '0;
                    bus.rsp_match   <= bus.sum_valid && bus.sum == expected_sum(bus.N);
                    bus.rsp_timeout <= !bus.sum_valid;
                end
                default: begin
                    state           <= IDLE;
                    bus.cmd_ready   <= 1'b1;
                    bus.N           <= '0;
                    bus.rsp_valid   <= 1'b0;
                    bus.rsp_sum     <= '0;
                    bus.rsp_match   <= 1'b0;
                    bus.rsp_timeout <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nsum_requester.sv
// tb_nsum_requester: directed vectors and corner sequences for nsum_requester
module tb_nsum_requester;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [2:0] n;
        int         dly;
        logic [3:0] sum;
        logic [3:0] exp_sum;
        logic       exp_match;
        logic       exp_to;
        int         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int ncmp = 0;
    int nerr = 0;
    vec_t vecs[8];

    nsum_requester_if #(.ERR_W(8)) bus();

    nsum_requester #(.TIMEOUT(TIMEOUT), .ERR_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        bit got;
        chk("cmd_ready_idle", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_n = v.n;
        step;
        bus.cmd_valid = 1'b0;
        chk("n_valid_issue", int'(bus.N_valid), 1);
        chk("n_latched", int'(bus.N), int'(v.n));
        chk("cmd_ready_busy", int'(bus.cmd_ready), 0);
        step;
        chk("n_valid_wait", int'(bus.N_valid), 0);
        got = 1'b0;
        k = 1;
        while (!got && k <= 40) begin
            bus.sum_valid = (k == v.dly);
            bus.sum = v.sum;
            step;
            bus.sum_valid = 1'b0;
            k++;
            if (bus.rsp_valid) got = 1'b1;
        end
        chk("rsp_seen", int'(got), 1);
        chk("rsp_cycle", k, v.dly != 0 ? v.dly + 1 : TIMEOUT + 1);
        chk("rsp_sum", int'(bus.rsp_sum), int'(v.exp_sum));
        chk("rsp_match", int'(bus.rsp_match), int'(v.exp_match));
        chk("rsp_timeout", int'(bus.rsp_timeout), int'(v.exp_to));
        chk("n_hold_resp", int'(bus.N), int'(v.n));
        step;
        chk("err_cnt", int'(bus.err_cnt), v.exp_err);
        chk("rsp_valid_drop", int'(bus.rsp_valid), 0);
        chk("cmd_ready_back", int'(bus.cmd_ready), 1);
        chk("n_idle", int'(bus.N), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        vecs[0] = '{3'd3, 2, 4'd6, 4'd6, 1'b1, 1'b0, 0};
        vecs[1] = '{3'd5, 1, 4'd15, 4'd15, 1'b1, 1'b0, 0};
        vecs[2] = '{3'd7, 3, 4'd12, 4'd12, 1'b1, 1'b0, 0};
        vecs[3] = '{3'd7, 1, 4'd13, 4'd13, 1'b0, 1'b0, 1};
        vecs[4] = '{3'd0, 0, 4'd0, 4'd0, 1'b0, 1'b1, 2};
        vecs[5] = '{3'd4, 16, 4'd10, 4'd10, 1'b1, 1'b0, 2};
        vecs[6] = '{3'd6, 5, 4'd5, 4'd5, 1'b1, 1'b0, 2};
        vecs[7] = '{3'd1, 15, 4'd1, 4'd1, 1'b1, 1'b0, 2};
        bus.cmd_valid = 1'b0;
        bus.cmd_n = '0;
        bus.sum = '0;
        bus.sum_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_n", int'(bus.N), 0);
        chk("rst_n_valid", int'(bus.N_valid), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_err_cnt", int'(bus.err_cnt), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        bus.sum_valid = 1'b1;
        step;
        bus.sum_valid = 1'b0;
        chk("spur_idle_err", int'(bus.err_cnt), 3);
        chk("spur_idle_rsp", int'(bus.rsp_valid), 0);
        chk("spur_idle_ready", int'(bus.cmd_ready), 1);
        step;
        chk("spur_idle_n_valid", int'(bus.N_valid), 0);

        bus.cmd_valid = 1'b1;
        bus.cmd_n = 3'd2;
        step;
        bus.cmd_valid = 1'b0;
        step;
        bus.sum_valid = 1'b1;
        bus.sum = 4'd9;
        step;
        chk("dbl_rsp_valid", int'(bus.rsp_valid), 1);
        chk("dbl_rsp_match", int'(bus.rsp_match), 0);
        chk("dbl_rsp_sum", int'(bus.rsp_sum), 9);
        step;
        bus.sum_valid = 1'b0;
        chk("dbl_err_cnt", int'(bus.err_cnt), 5);
        chk("dbl_rsp_drop", int'(bus.rsp_valid), 0);

        bus.sum_valid = 1'b1;
        repeat (300) step;
        bus.sum_valid = 1'b0;
        chk("sat_err_cnt", int'(bus.err_cnt), 255);
        chk("sat_rsp_valid", int'(bus.rsp_valid), 0);
        chk("sat_cmd_ready", int'(bus.cmd_ready), 1);

        bus.cmd_valid = 1'b1;
        bus.cmd_n = 3'd2;
        step;
        bus.cmd_valid = 1'b0;
        step;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("mid_rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("mid_rst_n", int'(bus.N), 0);
        chk("mid_rst_n_valid", int'(bus.N_valid), 0);
        chk("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("mid_rst_err_cnt", int'(bus.err_cnt), 0);
        seen = 0;
        repeat (20) begin
            step;
            if (bus.rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", seen, 0);
        run_vec('{3'd2, 1, 4'd3, 4'd3, 1'b1, 1'b0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/nsum_requester.md
# nsum_requester

Initiator for the NSum interface. It accepts triangular-sum requests on a ready/valid command port, drives `N`/`N_valid` to an NSum responder, and waits for `sum_valid` under a timeout. It then reports the captured sum, a match flag against the expected value, and a running error count. It sits between test/control logic and an `NSum` instance, on the requesting end of the same `N`/`sum` interface.

## Interface
- `TIMEOUT`, 16: maximum cycles spent in WAIT before declaring a timeout; range 2..255.
- `ERR_W`, 8: width of the saturating error counter.
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  request present.
- `cmd_n`  in  3  requested N.
- `cmd_ready`  out  1  block can accept a request; high only in IDLE.
- `N`  out  3  N driven to the responder.
- `N_valid`  out  1  one-cycle request strobe to the responder.
- `sum`  in  4  responder result.
- `sum_valid`  in  1  responder result strobe.
- `rsp_valid`  out  1  one-cycle result strobe.
- `rsp_sum`  out  4  captured `sum`; 0 on timeout.
- `rsp_match`  out  1  `rsp_sum` equals the expected value; 0 on timeout.
- `rsp_timeout`  out  1  no `sum_valid` seen within `TIMEOUT` cycles.
- `err_cnt`  out  `ERR_W`  saturating count of mismatches, timeouts and spurious `sum_valid`.

## Operation
- Expected value: N·(N+1)/2 mod 16, computed at 4 bits.
  - N = 0..7 gives 0, 1, 3, 6, 10, 15, 5, 12.
- States:
  - IDLE: `cmd_ready` = 1. When `cmd_valid` is high, latch `cmd_n` and go to ISSUE.
  - ISSUE: `N_valid` = 1 for exactly one cycle. Clear the timer and go to WAIT.
  - WAIT: `N_valid` = 0 and the timer increments each cycle.
    - If `sum_valid` = 1: capture `sum` and go to RESP with timeout = 0.
    - Else, if the timer reaches `TIMEOUT`: go to RESP with timeout = 1 and sum = 0.
    - If both happen in the same cycle, `sum_valid` wins and no timeout is reported.
  - RESP: `rsp_valid` = 1 for one cycle, then go to IDLE.
- `N` holds the latched value from ISSUE through RESP. In IDLE it is 0.
- `sum_valid` is only sampled in WAIT. A `sum_valid` in IDLE, ISSUE or RESP is spurious: `err_cnt` += 1 and no other effect.
- `err_cnt` increments by 1 per event: a RESP with `rsp_match` = 0, or a spurious strobe. When a spurious strobe and an error RESP land in the same cycle, it increments by 2. It saturates at all-ones.
- Reset, including mid-WAIT or mid-RESP:
  - the in-flight request is abandoned with no `rsp_valid`;
  - state returns to IDLE;
  - all outputs and counters are zero except `cmd_ready` = 1 in the first cycle after reset.

## Timing
- Command accepted at edge t:
  - `N_valid` is high in cycle t+1;
  - WAIT starts in cycle t+2.
- A responder `sum_valid` in WAIT cycle k, with the first WAIT cycle being k = 1, gives `rsp_valid` in cycle k+1 after WAIT entry.
- Minimum command-to-response latency is 3 cycles.
- On timeout, `rsp_valid` occurs `TIMEOUT` + 1 cycles after WAIT entry.
- Back-to-back throughput is one request per 4 cycles minimum. `cmd_ready` drops the cycle after acceptance.
- All outputs are registered. `rsp_*` fields are only meaningful while `rsp_valid` is high and read 0 otherwise.

## Structure
- Package `nsum_pkg` holds:
  - `N_W` = 3 and `SUM_W` = 4;
  - the state enum `nsum_req_state_t` (IDLE, ISSUE, WAIT, RESP);
  - `function expected_sum(N)`.
- One sub-module, `nsum_timer`: a clearable up-counter with a `hit` output at `TIMEOUT`. The FSM, latch and error counter stay in `nsum_requester`.

## Test plan
- Responder returns 6 two cycles after `N_valid` for `cmd_n` = 3 → `rsp_valid` one cycle later with `rsp_sum` = 6, `rsp_match` = 1, `rsp_timeout` = 0, `err_cnt` = 0.
- `cmd_n` = 5 then 7, responder returns 15 then 12 → both `rsp_match` = 1. A returned 13 for N = 7 gives `rsp_match` = 0 and `err_cnt` = 1.
- No `sum_valid`, `TIMEOUT` = 16 → `rsp_timeout` = 1 and `rsp_sum` = 0 exactly 17 cycles after WAIT entry; `err_cnt` += 1.
- `sum_valid` in the same cycle the timer hits → normal response with `rsp_timeout` = 0.
- `sum_valid` pulsed in IDLE → `err_cnt` = 1, no `rsp_valid`, state stays IDLE.
- `reset` asserted for one cycle during WAIT of an N = 2 request → no `rsp_valid`, `N` = 0, `cmd_ready` = 1 next cycle. A new N = 2 request then completes with `rsp_sum` = 3.
